apu_sample_mixer: RTL and testbench

- Upstream feeder of the I2S audio DAC serializer. Takes the five NES APU channel levels, mixes them with a fixed-point linear approximation, and boxcar-averages them over each LRCK frame.
- Presents one stable 16-bit signed sample per frame. The sample changes only just after an LRCK falling edge, so the serializer never shifts out a word that changes mid-transmission.
- Runs entirely on the 18.432 MHz audio clock. APU levels arrive as quasi-static, already-synchronised levels.

---
 rtl/apu_sample_mixer.sv | 107 ++++++++++
 tb/tb_apu_sample_mixer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_sample_mixer.sv
// NES APU channel mixer feeding the I2S serializer: linear weighted mix, boxcar
// average over each LRCK frame, one stable signed sample published per frame.
module apu_sample_mixer #(
  parameter int unsigned W_PULSE    = 752,
  parameter int unsigned W_TRI      = 851,
  parameter int unsigned W_NOISE    = 494,
  parameter int unsigned W_DMC      = 335,
  parameter int unsigned RECIP      = 683,
  parameter int unsigned OUT_OFFSET = 21320,
  parameter int unsigned MAX_WIN    = 511
) (
  input  logic        iCLK_18_4,
  input  logic        iRST_N,
  input  logic [3:0]  iPULSE1,
  input  logic [3:0]  iPULSE2,
  input  logic [3:0]  iTRI,
  input  logic [3:0]  iNOISE,
  input  logic [6:0]  iDMC,
  input  logic        iMUTE,
  input  logic        iLRCK,
  output logic [15:0] oSAMPLE,
  output logic        oSAMPLE_VALID,
  output logic        oOVERRUN
);

  localparam logic [8:0]         CNT_MAX  = 9'(MAX_WIN);
  localparam logic [35:0]        RECIP_W  = 36'(RECIP);
  localparam logic signed [17:0] OFFSET_S = 18'(OUT_OFFSET);
  localparam logic signed [17:0] SAT_HI   = 18'sd32767;
  localparam logic signed [17:0] SAT_LO   = -18'sd32768;

  logic [16:0]        mix_next;
  logic [16:0]        mix_r;
  logic               lrck_d;
  logic               fall;
  logic [25:0]        acc;
  logic [8:0]         cnt;
  logic [25:0]        sum_f;
  logic [16:0]        avg;
  logic               fall_d1;
  logic               fall_d2;
  logic signed [17:0] level;
  logic [15:0]        sample_next;

  always_comb begin
    mix_next = 17'(W_PULSE * (32'(iPULSE1) + 32'(iPULSE2)) + W_TRI * 32'(iTRI)
                 + W_NOISE * 32'(iNOISE) + W_DMC * 32'(iDMC));
  end

  assign fall = lrck_d & ~iLRCK;

  // Offset-removed level, saturated to the 16-bit DAC range.
  always_comb begin
    level = $signed(18'(avg >> 1)) - OFFSET_S;
    if (level > SAT_HI) begin
      sample_next = 16'h7FFF;
    end else if (level < SAT_LO) begin
      sample_next = 16'h8000;
    end else begin
      sample_next = level[15:0];
    end
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      mix_r         <= '0;
      lrck_d        <= 1'b0;
      acc           <= '0;
      cnt           <= '0;
      sum_f         <= '0;
      avg           <= '0;
      fall_d1       <= 1'b0;
      fall_d2       <= 1'b0;
      oSAMPLE       <= '0;
      oSAMPLE_VALID <= 1'b0;
      oOVERRUN      <= 1'b0;
    end else begin
      mix_r   <= mix_next;
      lrck_d  <= iLRCK;
      fall_d1 <= fall;
      fall_d2 <= fall_d1;

      // The fall cycle closes the window and the next one starts empty.
      if (fall) begin
        sum_f <= acc + ((cnt < CNT_MAX) ? 26'(mix_r) : 26'd0);
        acc   <= '0;
        cnt   <= '0;
      end else if (cnt < CNT_MAX) begin
        acc <= acc + 26'(mix_r);
        cnt <= cnt + 9'd1;
      end else begin
        oOVERRUN <= 1'b1;
      end

      // Divide by the nominal 384-cycle window via a reciprocal multiply.
      if (fall_d1) begin
        avg <= 17'((36'(sum_f) * RECIP_W) >> 18);
      end

      oSAMPLE_VALID <= fall_d2;
      if (fall_d2) begin
        oSAMPLE <= iMUTE ? 16'd0 : sample_next;
      end
    end
  end

endmodule

// File: tb/tb_apu_sample_mixer.sv
// Bench for apu_sample_mixer: window/queue reference model checked every cycle,
// table of steady-level frames, and hand sequences for overrun, reset, back-to-back falls.
`timescale 1ns/1ps
module tb_apu_sample_mixer;

  typedef struct {
    logic [3:0] p1;
    logic [3:0] p2;
    logic [3:0] tri_l;
    logic [3:0] noise;
    logic [6:0] dmc;
    logic       mute;
    logic       lrck;
    logic       rst_n;
  } in_t;

  typedef struct {
    logic [3:0]  p1;
    logic [3:0]  p2;
    logic [3:0]  tri_l;
    logic [3:0]  noise;
    logic [6:0]  dmc;
    logic        mute;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    int              due;
    longint unsigned sum;
  } pend_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  pulse1, pulse2, tri_lvl, noise;
  logic [6:0]  dmc;
  logic        mute, lrck;
  logic [15:0] sample;
  logic        sample_valid;
  logic        overrun;

  apu_sample_mixer dut (
    .iCLK_18_4    (clk),
    .iRST_N       (rst_n),
    .iPULSE1      (pulse1),
    .iPULSE2      (pulse2),
    .iTRI         (tri_lvl),
    .iNOISE       (noise),
    .iDMC         (dmc),
    .iMUTE        (mute),
    .iLRCK        (lrck),
    .oSAMPLE      (sample),
    .oSAMPLE_VALID(sample_valid),
    .oOVERRUN     (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #27 clk = ~clk;

  // scoreboard state
  int unsigned     win[$];
  pend_t           pend_q[$];
  logic [15:0]     exp_q[$];
  int unsigned     prev_mix;
  logic            prev_lrck;
  logic [15:0]     exp_sample;
  logic            exp_valid;
  logic            exp_overrun;
  int              cyc;
  int              n_checks;
  int              n_pass;
  int              valid_seen;
  in_t             cur;
  vec_t            tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic int unsigned mix_of(input in_t v);
    return 752 * (int'(v.p1) + int'(v.p2)) + 851 * int'(v.tri_l)
         + 494 * int'(v.noise) + 335 * int'(v.dmc);
  endfunction

  function automatic logic [15:0] sample_of(input longint unsigned sum, input logic m);
    longint unsigned avg;
    longint          s;
    logic [15:0]     r;
    if (m) return 16'h0000;
    avg = (sum * 683) >> 18;
    s   = longint'(avg / 2) - 21320;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    r = s[15:0];
    return r;
  endfunction

  task automatic model_reset();
    win.delete();
    pend_q.delete();
    exp_q.delete();
    prev_mix    = 0;
    prev_lrck   = 1'b0;
    exp_sample  = 16'h0000;
    exp_valid   = 1'b0;
    exp_overrun = 1'b0;
  endtask

  // Advance the reference by one cycle whose inputs are v; leaves expectations for the next cycle.
  task automatic model_cycle(input in_t v);
    longint unsigned s;
    pend_t           keep[$];
    exp_valid = 1'b0;
    if (!v.rst_n) begin
      model_reset();
      return;
    end
    if (prev_lrck && !v.lrck) begin
      s = 0;
      foreach (win[i]) s += win[i];
      if (win.size() < 511) s += prev_mix;
      win.delete();
      pend_q.push_back('{due: cyc + 3, sum: s});
    end else if (win.size() < 511) begin
      win.push_back(prev_mix);
    end else begin
      exp_overrun = 1'b1;
    end
    keep.delete();
    foreach (pend_q[i]) begin
      if (pend_q[i].due == cyc + 1) begin
        exp_q.push_back(sample_of(pend_q[i].sum, v.mute));
        exp_valid = 1'b1;
      end else begin
        keep.push_back(pend_q[i]);
      end
    end
    pend_q = keep;
    prev_mix  = mix_of(v);
    prev_lrck = v.lrck;
  endtask

  // driver tasks
  task automatic drive(input in_t v);
    pulse1  = v.p1;
    pulse2  = v.p2;
    tri_lvl = v.tri_l;
    noise   = v.noise;
    dmc     = v.dmc;
    mute    = v.mute;
    lrck    = v.lrck;
    rst_n   = v.rst_n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (exp_valid && exp_q.size() > 0) exp_sample = exp_q.pop_front();
    if (sample_valid) valid_seen++;
    check("sample", {16'h0, sample}, {16'h0, exp_sample});
    check("valid", {31'h0, sample_valid}, {31'h0, exp_valid});
    check("overrun", {31'h0, overrun}, {31'h0, exp_overrun});
  endtask

  task automatic run_cycle(input in_t v);
    tick();
    drive(v);
    model_cycle(v);
  endtask

  task automatic frame(input int hi, input int lo);
    cur.lrck = 1'b1;
    repeat (hi) run_cycle(cur);
    cur.lrck = 1'b0;
    repeat (lo) run_cycle(cur);
  endtask

  task automatic set_levels(input logic [3:0] a, input logic [3:0] b, input logic [3:0] t,
                            input logic [3:0] n, input logic [6:0] d);
    cur.p1 = a; cur.p2 = b; cur.tri_l = t; cur.noise = n; cur.dmc = d;
  endtask

  task automatic rand_levels();
    set_levels(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)));
  endtask

  task automatic rand_half(input int n, input logic lv);
    cur.lrck = lv;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 63) == 0) rand_levels();
      if ($urandom_range(0, 127) == 0) cur.mute = ~cur.mute;
      run_cycle(cur);
    end
  endtask

  task automatic reset_mid();
    tick();
    cur.rst_n = 1'b0;
    drive(cur);
    model_cycle(cur);
    #1;
    check("rst_sample_now", {16'h0, sample}, 32'h0);
    check("rst_valid_now", {31'h0, sample_valid}, 32'h0);
    check("rst_overrun_now", {31'h0, overrun}, 32'h0);
    repeat (3) run_cycle(cur);
    cur.rst_n = 1'b1;
    run_cycle(cur);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; valid_seen = 0;
    cur = '{p1: 4'd0, p2: 4'd0, tri_l: 4'd0, noise: 4'd0, dmc: 7'd0,
            mute: 1'b0, lrck: 1'b0, rst_n: 1'b0};
    drive(cur);
    model_reset();
    repeat (3) run_cycle(cur);
    cur.rst_n = 1'b1;
    run_cycle(cur);

    // steady-level frames: second frame of each row sees a full clean window
    tbl[0] = '{p1: 4'd0,  p2: 4'd0,  tri_l: 4'd0,  noise: 4'd0,  dmc: 7'd0,   mute: 1'b0, exp: 16'hACB8};
    tbl[1] = '{p1: 4'd15, p2: 4'd15, tri_l: 4'd15, noise: 4'd15, dmc: 7'd127, mute: 1'b0, exp: 16'h535C};
    tbl[2] = '{p1: 4'd15, p2: 4'd0,  tri_l: 4'd0,  noise: 4'd0,  dmc: 7'd0,   mute: 1'b0, exp: 16'hC2C2};
    tbl[3] = '{p1: 4'd0,  p2: 4'd0,  tri_l: 4'd15, noise: 4'd0,  dmc: 7'd0,   mute: 1'b0, exp: 16'hC5A9};
    tbl[4] = '{p1: 4'd0,  p2: 4'd0,  tri_l: 4'd0,  noise: 4'd0,  dmc: 7'd127, mute: 1'b0, exp: 16'hFFDA};
    tbl[5] = '{p1: 4'd15, p2: 4'd15, tri_l: 4'd15, noise: 4'd15, dmc: 7'd127, mute: 1'b1, exp: 16'h0000};
    tbl[6] = '{p1: 4'd15, p2: 4'd15, tri_l: 4'd15, noise: 4'd15, dmc: 7'd127, mute: 1'b0, exp: 16'h535C};
    for (int i = 0; i < 7; i++) begin
      set_levels(tbl[i].p1, tbl[i].p2, tbl[i].tri_l, tbl[i].noise, tbl[i].dmc);
      cur.mute = tbl[i].mute;
      frame(192, 192);
      frame(192, 192);
      check($sformatf("table_row%0d", i), {16'h0, sample}, {16'h0, tbl[i].exp});
    end

    // long high LRCK with max levels: window saturates, overrun sticks
    cur.lrck = 1'b1;
    repeat (600) run_cycle(cur);
    check("overrun_set", {31'h0, overrun}, 32'h1);
    cur.lrck = 1'b0;
    repeat (10) run_cycle(cur);
    check("overrun_clamped", {16'h0, sample}, 32'h7FFF);
    frame(192, 192);
    frame(192, 192);
    check("overrun_sticky", {31'h0, overrun}, 32'h1);
    check("after_overrun", {16'h0, sample}, 32'h535C);

    // back-to-back falls: one valid pulse per fall
    cur.lrck = 1'b0;
    repeat (5) run_cycle(cur);
    valid_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cur.lrck = (i % 2 == 0);
      run_cycle(cur);
    end
    cur.lrck = 1'b0;
    repeat (6) run_cycle(cur);
    check("b2b_pulses", 32'(valid_seen), 32'd3);

    // reset mid-window: partial first frame, clean second frame
    cur.lrck = 1'b1;
    repeat (100) run_cycle(cur);
    reset_mid();
    frame(192, 192);
    frame(192, 192);
    check("post_reset_frame", {16'h0, sample}, 32'h535C);
    check("post_reset_overrun", {31'h0, overrun}, 32'h0);

    // randomized levels, mute, frame lengths and mid-window changes
    for (int f = 0; f < 30; f++) begin
      rand_levels();
      if ($urandom_range(0, 4) == 0) begin
        rand_half($urandom_range(1, 3), 1'b1);
        rand_half($urandom_range(1, 3), 1'b0);
      end else begin
        rand_half($urandom_range(100, 250), 1'b1);
        rand_half($urandom_range(100, 250), 1'b0);
      end
    end
    repeat (5) run_cycle(cur);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
